// File: rtl/lock_seq_if.sv
// Command/result bundle for lock_seq_monitor.
// Master drives commands and clear; slave returns readiness, results and status.
interface lock_seq_if #(
  parameter int NLOCKS = 4,
  parameter int CNTW   = 16
);
  logic                  cmd_valid;
  logic [2*NLOCKS-1:0]   cmd;
  logic                  cmd_ready;
  logic                  clear;
  logic                  out_valid;
  logic [NLOCKS:0]       out;
  logic [NLOCKS-1:0]     locks;
  logic                  fault;
  logic [NLOCKS-1:0]     bad_mask;
  logic [CNTW-1:0]       fault_step;
  logic [CNTW-1:0]       step;
  logic                  state_dbg;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // the source holds cmd stable while cmd_valid is high and cmd_ready is low.
  modport master (
    output cmd_valid, cmd, clear,
    input  cmd_ready, out_valid, out, locks, fault, bad_mask, fault_step, step,
           state_dbg
  );

  modport slave (
    input  cmd_valid, cmd, clear,
    output cmd_ready, out_valid, out, locks, fault, bad_mask, fault_step, step,
           state_dbg
  );
endinterface

// File: rtl/lock_seq_monitor.sv
// Sequential lock-command monitor: holds lock state, applies one command per
// handshake, and latches the first illegal command until clear or reset.
module lock_seq_monitor #(
  parameter int                NLOCKS     = 4,
  parameter logic [NLOCKS-1:0] INIT_LOCKS = '0,
  parameter int                CNTW       = 16
) (
  input  logic        clk,
  input  logic        rst,
  lock_seq_if.slave   bus
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [NLOCKS-1:0]   locks_q, locks_d;
  logic                fault_q, fault_d;
  logic [NLOCKS-1:0]   bad_q, bad_d;
  logic [CNTW-1:0]     fstep_q, fstep_d;
  logic [CNTW-1:0]     step_q, step_d;
  logic                out_valid_q, out_valid_d;
  logic [NLOCKS:0]     out_q, out_d;

  logic [NLOCKS-1:0]   bad, upd;
  logic                accept;

  // Combinational checker: a lock is bad when a non-skipped op repeats its state.
  always_comb begin
    bad = '0;
    upd = '0;
    for (int i = 0; i < NLOCKS; i++) begin
      bad[i] = !bus.cmd[2*i+1] && (bus.cmd[2*i] == locks_q[i]);
      upd[i] = bus.cmd[2*i+1] ? locks_q[i] : bus.cmd[2*i];
    end
  end

  assign bus.cmd_ready = (state_q == RUN) && !bus.clear && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d     = state_q;
    locks_d     = locks_q;
    fault_d     = fault_q;
    bad_d       = bad_q;
    fstep_d     = fstep_q;
    step_d      = step_q;
    out_valid_d = 1'b0;
    out_d       = out_q;
    if (bus.clear) begin
      state_d = RUN;
      locks_d = INIT_LOCKS;
      fault_d = 1'b0;
      bad_d   = '0;
      fstep_d = '0;
      step_d  = '0;
      out_d   = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      if (|bad) begin
        // Illegal command is applied to no lock, not even the legal ones.
        state_d = FAULT;
        fault_d = 1'b1;
        bad_d   = bad;
        fstep_d = step_q;
        out_d   = {1'b1, locks_q};
      end else begin
        locks_d = upd;
        step_d  = (step_q == {CNTW{1'b1}}) ? step_q : step_q + 1'b1;
        out_d   = {1'b0, upd};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      locks_q     <= INIT_LOCKS;
      fault_q     <= 1'b0;
      bad_q       <= '0;
      fstep_q     <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      locks_q     <= locks_d;
      fault_q     <= fault_d;
      bad_q       <= bad_d;
      fstep_q     <= fstep_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out        = out_q;
  assign bus.locks      = locks_q;
  assign bus.fault      = fault_q;
  assign bus.bad_mask   = bad_q;
  assign bus.fault_step = fstep_q;
  assign bus.step       = step_q;
  assign bus.state_dbg  = state_q;

endmodule
